// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: 32-bit loads/stores over a 16-bit SRAM (two half-word accesses)
// plus the MEM/WB register. Define EXTERNAL_SRAM_EN for the SRAM path; otherwise an internal array is used.
module mem_stage_sram_ctrl #(
  parameter int SRAM_WAIT  = 2,
  parameter int ADDR_BASE  = 1024,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] ST_val_in,
  input  logic [3:0]  Dest_in,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_Result,
  output logic [31:0] MEM_Result,
  output logic [3:0]  Dest
);

  localparam logic [31:0] BASE = 32'(ADDR_BASE);

  logic [31:0] w_off;
  logic [16:0] w_word;
  logic        w_req;
  logic        w_rd;
  logic        w_ready;
  logic [31:0] w_mem_result;

  assign w_off  = ALU_Result_in - BASE;
  assign w_word = w_off[18:2];
  assign w_req  = MEM_R_EN_in | MEM_W_EN_in;
  // A write wins over a read when both enables are set.
  assign w_rd   = MEM_R_EN_in & ~MEM_W_EN_in;

`ifdef EXTERNAL_SRAM_EN
  localparam int CW = $clog2(SRAM_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [15:0]     r_rd_lo;
  logic [15:0]     r_rd_hi;
  logic            w_last;
  logic            w_unused;

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd_lo <= '0;
      r_rd_hi <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_LO && w_last && w_rd) r_rd_lo <= SRAM_DQ_in;
      if (r_state == S_HI && w_last && w_rd) r_rd_hi <= SRAM_DQ_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_LO;
          w_cnt_nxt   = '0;
        end
      end
      S_LO: begin
        if (w_last) begin
          w_state_nxt = S_HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HI: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // SRAM pins are purely a function of state, so reset silences them immediately.
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_WE_N   = 1'b1;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    if (r_state == S_LO || r_state == S_HI) begin
      SRAM_ADDR = {w_word, (r_state == S_HI)};
      if (MEM_W_EN_in) begin
        SRAM_DQ_oe  = 1'b1;
        SRAM_DQ_out = (r_state == S_HI) ? ST_val_in[31:16] : ST_val_in[15:0];
        SRAM_WE_N   = w_last;
      end
    end
  end

  assign w_ready      = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  assign w_mem_result = w_rd ? {r_rd_hi, r_rd_lo} : 32'h0;
  assign w_unused     = ^{w_off[31:19], w_off[1:0]};
`else
  localparam int IW = $clog2(DMEM_WORDS);

  logic [31:0]   r_dmem [DMEM_WORDS];
  logic [16:0]   w_mod;
  logic [IW-1:0] w_idx;
  logic          w_unused;

  assign w_mod = w_word % 17'(DMEM_WORDS);
  assign w_idx = w_mod[IW-1:0];

  always_ff @(posedge clk) begin
    if (MEM_W_EN_in) r_dmem[w_idx] <= ST_val_in;
  end

  assign w_ready      = 1'b1;
  assign w_mem_result = w_rd ? r_dmem[w_idx] : 32'h0;
  assign SRAM_ADDR    = '0;
  assign SRAM_WE_N    = 1'b1;
  assign SRAM_DQ_out  = '0;
  assign SRAM_DQ_oe   = 1'b0;
  assign w_unused     = ^{w_off[31:19], w_off[1:0], w_mod[16:IW], w_req, SRAM_DQ_in};
`endif

  assign ready = w_ready;

  // A stalled cycle inserts a bubble so the frozen instruction writes back only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_EN      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      ALU_Result <= '0;
      MEM_Result <= '0;
      Dest       <= '0;
    end else if (w_ready) begin
      WB_EN      <= WB_EN_in;
      MEM_R_EN   <= MEM_R_EN_in;
      ALU_Result <= ALU_Result_in;
      MEM_Result <= w_mem_result;
      Dest       <= Dest_in;
    end else begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed table, reset-mid-access sequence and
// random traffic against a word-level memory model; follows EXTERNAL_SRAM_EN like the design.
module tb_mem_stage_sram_ctrl;

  localparam int SRAM_WAIT  = 2;
  localparam int ADDR_BASE  = 1024;
  localparam int DMEM_WORDS = 64;
`ifdef EXTERNAL_SRAM_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_Result_in, ST_val_in;
  logic [3:0]  Dest_in;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic [15:0] SRAM_DQ_in;
  logic        WB_EN, MEM_R_EN;
  logic [31:0] ALU_Result, MEM_Result;
  logic [3:0]  Dest;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .SRAM_WAIT (SRAM_WAIT),
    .ADDR_BASE (ADDR_BASE),
    .DMEM_WORDS(DMEM_WORDS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_EN_in     (WB_EN_in),
    .MEM_R_EN_in  (MEM_R_EN_in),
    .MEM_W_EN_in  (MEM_W_EN_in),
    .ALU_Result_in(ALU_Result_in),
    .ST_val_in    (ST_val_in),
    .Dest_in      (Dest_in),
    .ready        (ready),
    .SRAM_ADDR    (SRAM_ADDR),
    .SRAM_WE_N    (SRAM_WE_N),
    .SRAM_DQ_out  (SRAM_DQ_out),
    .SRAM_DQ_oe   (SRAM_DQ_oe),
    .SRAM_DQ_in   (SRAM_DQ_in),
    .WB_EN        (WB_EN),
    .MEM_R_EN     (MEM_R_EN),
    .ALU_Result   (ALU_Result),
    .MEM_Result   (MEM_Result),
    .Dest         (Dest)
  );

`ifdef EXTERNAL_SRAM_EN
  logic [15:0] sram [0:262143];
  initial for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
  always @(posedge clk) if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR] <= SRAM_DQ_out;
  assign SRAM_DQ_in = sram[SRAM_ADDR];
`else
  // Noise on the unused bus: the internal array must ignore it.
  always @(posedge clk) SRAM_DQ_in <= 16'($urandom);
`endif

  function automatic int key_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'(ADDR_BASE);
    if (EXT) return int'(d[18:2]);
    return int'(d[18:2]) % DMEM_WORDS;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int k;
    k = key_of(a);
    return model_mem.exists(k) ? model_mem[k] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    ALU_Result_in = 32'h0; ST_val_in = 32'h0; Dest_in = 4'h0;
  endtask

  // Called just after a rising edge; returns just after the edge that retires the instruction.
  task automatic run_instr(input logic wb, input logic mr, input logic mw,
                           input logic [31:0] alu, input logic [31:0] st,
                           input logic [3:0] dest, input logic [31:0] exp_res,
                           input string name);
    int i, low, cnt, exp_low;
    logic r, hi;
    logic [31:0] d;
    logic [16:0] w;
    logic [17:0] ea;
    logic ewe, eoe;
    logic [15:0] edq;
    WB_EN_in = wb; MEM_R_EN_in = mr; MEM_W_EN_in = mw;
    ALU_Result_in = alu; ST_val_in = st; Dest_in = dest;
    d = alu - 32'(ADDR_BASE);
    w = d[18:2];
    exp_low = (EXT && (mr || mw)) ? 2 * SRAM_WAIT + 1 : 0;
    i = 0; low = 0;
    forever begin
      @(negedge clk);
      ea = '0; ewe = 1'b1; eoe = 1'b0; edq = '0;
      if (EXT && (mr || mw) && i >= 1 && i <= 2 * SRAM_WAIT) begin
        hi  = (i > SRAM_WAIT);
        cnt = (i - 1) % SRAM_WAIT;
        ea  = {w, hi};
        if (mw) begin
          eoe = 1'b1;
          ewe = (cnt == SRAM_WAIT - 1);
          edq = hi ? st[31:16] : st[15:0];
        end
      end
      chk({name, "_addr"}, 32'(SRAM_ADDR), 32'(ea));
      chk({name, "_we_n"}, 32'(SRAM_WE_N), 32'(ewe));
      chk({name, "_oe"}, 32'(SRAM_DQ_oe), 32'(eoe));
      chk({name, "_dq"}, 32'(SRAM_DQ_out), 32'(edq));
      r = ready;
      if (!r) begin
        low++;
        if (i >= 1) begin
          chk({name, "_bubble_wb"}, 32'(WB_EN), 32'h0);
          chk({name, "_bubble_mr"}, 32'(MEM_R_EN), 32'h0);
        end
      end
      @(posedge clk); #1;
      i++;
      if (r) break;
      if (i > 2 * SRAM_WAIT + 4) begin
        chk({name, "_timeout"}, 32'(r), 32'h1);
        break;
      end
    end
    chk({name, "_stall_cycles"}, 32'(low), 32'(exp_low));
    chk({name, "_wb_en"}, 32'(WB_EN), 32'(wb));
    chk({name, "_mem_r_en"}, 32'(MEM_R_EN), 32'(mr));
    chk({name, "_alu"}, ALU_Result, alu);
    chk({name, "_mem_res"}, MEM_Result, exp_res);
    chk({name, "_dest"}, 32'(Dest), 32'(dest));
    if (mw) model_mem[key_of(alu)] = st;
  endtask

  typedef struct {
    logic        wb, mr, mw;
    logic [31:0] alu, st;
    logic [3:0]  dest;
    logic [31:0] exp_res;
    string       name;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] a, s, e;
    int kind;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h55,        32'h0,        4'd3,  32'h0,        "alu_pass"};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'd1032,      32'hDEADBEEF, 4'd0,  32'h0,        "store"};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'd1032,      32'h0,        4'd7,  32'hDEADBEEF, "load"};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd1036,      32'h12345678, 4'd5,  32'h0,        "conflict"};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'd1036,      32'h0,        4'd9,  32'h12345678, "load_conflict"};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'd1033,      32'h0,        4'd2,  32'hDEADBEEF, "load_unaligned"};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF,  32'h0,        4'd15, 32'h0,        "alu_ones"};

    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wb_en", 32'(WB_EN), 32'h0);
    chk("rst_mem_r_en", 32'(MEM_R_EN), 32'h0);
    chk("rst_alu", ALU_Result, 32'h0);
    chk("rst_mem_res", MEM_Result, 32'h0);
    chk("rst_dest", 32'(Dest), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'h1);
    chk("rst_oe", 32'(SRAM_DQ_oe), 32'h0);
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++)
      run_instr(tbl[t].wb, tbl[t].mr, tbl[t].mw, tbl[t].alu, tbl[t].st,
                tbl[t].dest, tbl[t].exp_res, tbl[t].name);

    // Word aliasing: internal array folds the index, the SRAM does not.
    a = 32'(ADDR_BASE + 4 * (DMEM_WORDS + 3));
    run_instr(1'b0, 1'b0, 1'b1, a, 32'hA5A5C3C3, 4'd1, 32'h0, "alias_store");
    a = 32'(ADDR_BASE + 12);
    e = model_rd(a);
    run_instr(1'b1, 1'b1, 1'b0, a, 32'h0, 4'd6, e, "alias_load");

    // Reset in the middle of a store.
    run_instr(1'b1, 1'b0, 1'b0, 32'hA5, 32'h0, 4'd4, 32'h0, "pre_abort");
    WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b1;
    ALU_Result_in = 32'(ADDR_BASE + 4 * 500); ST_val_in = 32'hCAFEF00D; Dest_in = 4'd0;
    if (EXT) begin
      repeat (SRAM_WAIT + 1) @(posedge clk);
      #1;
      chk("abort_hi_we_n", 32'(SRAM_WE_N), 32'h0);
      chk("abort_hi_oe", 32'(SRAM_DQ_oe), 32'h1);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(SRAM_WE_N), 32'h1);
    chk("abort_oe", 32'(SRAM_DQ_oe), 32'h0);
    chk("abort_addr", 32'(SRAM_ADDR), 32'h0);
    chk("abort_alu", ALU_Result, 32'h0);
    chk("abort_dest", 32'(Dest), 32'h0);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'h1);
    @(posedge clk); #1;

    for (int k = 0; k < DMEM_WORDS; k++)
      run_instr(1'b0, 1'b0, 1'b1, 32'(ADDR_BASE + 4 * k), $urandom, 4'd0, 32'h0, "prefill");

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      a = 32'(ADDR_BASE + 4 * $urandom_range(0, 127) + $urandom_range(0, 3));
      s = $urandom;
      case (kind)
        0: run_instr(1'($urandom), 1'b0, 1'b0, s, 32'h0, 4'($urandom), 32'h0, "rnd_alu");
        1: run_instr(1'b0, 1'b0, 1'b1, a, s, 4'($urandom), 32'h0, "rnd_store");
        2: begin
          e = model_rd(a);
          run_instr(1'b1, 1'b1, 1'b0, a, s, 4'($urandom), e, "rnd_load");
        end
        default: run_instr(1'($urandom), 1'b1, 1'b1, a, s, 4'($urandom), 32'h0, "rnd_both");
      endcase
    end

    drive_idle();
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory stage of the pipelined ARM core: consumes the EXE/MEM register outputs and performs loads and stores on a 16-bit external SRAM, splitting each 32-bit word into two half-word accesses. While an access is in progress it drops `ready` so the hazard/freeze logic stalls every earlier stage. It also contains the MEM/WB pipeline register feeding write-back.

## Interface
- `SRAM_WAIT`, default 2: cycles spent per half-word access; legal range is 2 or greater.
- `ADDR_BASE`, default 1024: byte address that maps to SRAM word 0.
- `DMEM_WORDS`, default 64: depth of the internal array, used only without `EXTERNAL_SRAM_EN`.
- `clk`  in  1  system clock; everything is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `WB_EN_in`, `MEM_R_EN_in`, `MEM_W_EN_in`  in  1 each  control signals from EXE/MEM.
- `ALU_Result_in`  in  32  byte address for memory ops, or the result for non-memory ops.
- `ST_val_in`  in  32  store data.
- `Dest_in`  in  4  destination register.
- `ready`  out  1  combinational; 0 freezes the pipeline.
- `SRAM_ADDR`  out  18  half-word address.
- `SRAM_WE_N`  out  1  write strobe, active-low.
- `SRAM_DQ_out`  out  16  write data.
- `SRAM_DQ_oe`  out  1  data-bus drive enable.
- `SRAM_DQ_in`  in  16  read data.
- `WB_EN`, `MEM_R_EN`  out  1 each  MEM/WB register outputs.
- `ALU_Result`, `MEM_Result`  out  32 each  MEM/WB register outputs.
- `Dest`  out  4  MEM/WB register output.

## Operation
- **Request:** `req = MEM_R_EN_in | MEM_W_EN_in`.
  - If both enables are set, the write wins and `MEM_Result` is 0.
- **Word address:** `w = (ALU_Result_in - ADDR_BASE)[18:2]`.
  - Address arithmetic is modulo 2^17 words; there is no range check.
- **Half-word addresses:** `SRAM_ADDR = {w, 0}` for the low half and `{w, 1}` for the high half.
- **FSM states:** IDLE, LO, HI, DONE. A counter `cnt` runs from 0 to `SRAM_WAIT`-1 within LO and HI.
  - IDLE: if `req`, go to LO with `cnt=0`.
  - LO: when `cnt == SRAM_WAIT-1`, go to HI with `cnt=0`; a read captures `SRAM_DQ_in` into `rd_lo` on this edge.
  - HI: same rule, going to DONE and capturing `rd_hi`.
  - DONE: go to IDLE unconditionally.
- **`ready`:** `ready = (IDLE & ~req) | DONE`.
- **SRAM drive in LO and HI** (combinational from state, `cnt` and the frozen inputs):
  - `SRAM_ADDR` as above.
  - For a write, `SRAM_DQ_oe = 1` and `SRAM_DQ_out = ST_val_in[15:0]` in LO, `ST_val_in[31:16]` in HI.
  - `SRAM_WE_N = 0` for `cnt < SRAM_WAIT-1`, and 1 on the last cycle of each half (address/data hold).
  - For a read, `SRAM_DQ_oe = 0` and `SRAM_WE_N = 1`.
- **SRAM drive in IDLE and DONE:** `SRAM_WE_N=1`, `SRAM_DQ_oe=0`, `SRAM_ADDR=0`, `SRAM_DQ_out=0`.
- **MEM/WB register:**
  - When `ready=1`, it loads the inputs, with `MEM_Result = {rd_hi, rd_lo}` for reads and 0 otherwise.
  - When `ready=0`, it loads a bubble (`WB_EN=0`, `MEM_R_EN=0`) and holds all other fields, so a frozen instruction is never written back twice.
- **Input stability:** upstream inputs are stable throughout LO/HI because the pipeline is frozen. No internal latch of address or data is needed.

## Timing
- **Reset:** state=IDLE, `cnt=0`, `rd_lo=rd_hi=0`, and every MEM/WB output is 0.
  - SRAM outputs go inactive at once, including mid-access.
  - An aborted write leaves the SRAM contents undefined for that word.
- **Non-memory instruction:** 1 cycle in MEM, `ready` stays 1.
- **Memory instruction:** `2*SRAM_WAIT+2` cycles in MEM.
  - `ready` is low for `2*SRAM_WAIT+1` cycles (IDLE request cycle, LO, HI).
  - `ready` is high in DONE, and MEM/WB captures the result on the DONE edge.
- **Back-to-back memory instructions:** the new instruction arrives after DONE and is seen in IDLE the next cycle, with no spurious re-trigger.

## Configuration
- **`EXTERNAL_SRAM_EN` defined:** the SRAM controller described above.
- **`EXTERNAL_SRAM_EN` undefined:** an internal array of `DMEM_WORDS` × 32 replaces the SRAM path.
  - Index is `w mod DMEM_WORDS`.
  - Write is synchronous, read is combinational, and each access takes 1 cycle.
  - `ready` is tied to 1 and the FSM is removed.
  - SRAM outputs are tied inactive (`WE_N=1`, `oe=0`, `addr=0`, `data=0`); `SRAM_DQ_in` is ignored.

## Test plan
- **Reset:** hold `rst`, then release with idle inputs → all MEM/WB outputs 0, `ready=1`, `SRAM_WE_N=1`, `SRAM_DQ_oe=0`.
- **ALU pass-through:** `WB_EN_in=1`, `ALU_Result_in=0x55`, `Dest_in=3` → `ready` stays 1; next edge gives `WB_EN=1`, `ALU_Result=0x55`, `Dest=3`.
- **Store:** `MEM_W_EN_in=1`, `ALU_Result_in=1032`, `ST_val_in=0xDEADBEEF`, `SRAM_WAIT=2` → `ready` low 5 cycles.
  - `SRAM_ADDR=4` with data `0xBEEF`, then `SRAM_ADDR=5` with data `0xDEAD`.
  - `WE_N` is low exactly 1 cycle per half.
  - `WB_EN` stays 0 throughout.
- **Load:** with the SRAM model holding that store, `MEM_R_EN_in=1`, `WB_EN_in=1`, `Dest_in=7`, same address → on the DONE edge `MEM_Result=0xDEADBEEF`, `WB_EN=1`, `Dest=7`.
- **Reset mid-access:** assert `rst` during HI of a store → `SRAM_WE_N=1` and `SRAM_DQ_oe=0` immediately; after release the FSM is in IDLE and `ready=1`.
- **Conflicting enables:** `MEM_R_EN_in=MEM_W_EN_in=1` → the write sequence is performed and `MEM_Result=0`.
